// File: rtl/systolic_pkg.sv
// systolic_pkg: state encoding, parameter defaults and drain-length helper for systolic_seq.
package systolic_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int MAC_LAT_DEF = 2;

    // read latency + skew/hop path to the far corner mac + accumulate latency
    function automatic int drain_cycles(input int n, input int mac_lat);
        return 1 + 2 * (n - 1) + mac_lat;
    endfunction
endpackage

// File: rtl/systolic_seq_skew.sv
// skew_line: DEPTH-stage {valid, data} delay line with async reset and sync flush; DEPTH=0 is a wire.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         src_valid,
    input  logic [W-1:0] src,
    output logic         dst_valid,
    output logic [W-1:0] dst
);
    if (DEPTH == 0) begin : g_wire
        logic unused;
        assign unused = ^{clk, reset, flush};
        assign dst_valid = src_valid;
        assign dst = src;
    end else begin : g_pipe
        logic [W:0] pipe [DEPTH];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int j = 0; j < DEPTH; j++) pipe[j] <= '0;
            end else begin
                pipe[0] <= flush ? '0 : {src_valid, src};
                for (int j = 1; j < DEPTH; j++) pipe[j] <= flush ? '0 : pipe[j-1];
            end
        end
        assign {dst_valid, dst} = pipe[DEPTH-1];
    end
endmodule

// File: rtl/systolic_seq.sv
// systolic_seq: clear/feed/drain sequencer driving the west and north edges of an N x N mac grid.
// Define SYSTOLIC_ABORT_EN to add the abort input and the aborted pulse.
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int N       = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int KW      = 8,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [KW-1:0]         rd_addr,
    input  logic [N*DATA_W-1:0]   a_rd_data,
    input  logic [N*DATA_W-1:0]   b_rd_data,
    output logic [N*DATA_W-1:0]   arr_a,
    output logic [N-1:0]          arr_valid_a,
    output logic [N*DATA_W-1:0]   arr_b,
    output logic [N-1:0]          arr_valid_b,
    output logic                  acc_clear
`ifdef SYSTOLIC_ABORT_EN
    ,
    input  logic                  abort,
    output logic                  aborted
`endif
);
    localparam int D  = drain_cycles(N, MAC_LAT);
    localparam int DW = $clog2(D + 1);

    state_t        state;
    logic [KW-1:0] k;
    logic [KW-1:0] k_len_q;
    logic [DW-1:0] drain;
    logic          fed;
    logic          kill;

`ifdef SYSTOLIC_ABORT_EN
    assign kill = abort && (state == CLEAR || state == FEED || state == DRAIN);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) aborted <= 1'b0;
        else aborted <= kill;
    end
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            k       <= '0;
            k_len_q <= '0;
            drain   <= '0;
            fed     <= 1'b0;
        end else if (kill) begin
            state <= IDLE;
            k     <= '0;
            drain <= '0;
            fed   <= 1'b0;
        end else begin
            fed <= state == FEED;
            case (state)
                IDLE: if (start) begin
                    state   <= CLEAR;
                    k_len_q <= k_len;
                end
                CLEAR: state <= k_len_q == '0 ? DONE : FEED;
                FEED: if (k == k_len_q - KW'(1)) begin
                    state <= DRAIN;
                    k     <= '0;
                    drain <= DW'(D - 1);
                end else begin
                    k <= k + KW'(1);
                end
                DRAIN: if (drain == '0) state <= DONE;
                       else drain <= drain - DW'(1);
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign rd_en     = state == FEED;
    assign rd_addr   = k;
    assign acc_clear = state == CLEAR;

    // fed is the lane-0 stage: raw read data qualified by last cycle's rd_en
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.DEPTH(i), .W(DATA_W)) a_line (
            .clk(clk), .reset(reset), .flush(kill), .src_valid(fed),
            .src(fed ? a_rd_data[i*DATA_W +: DATA_W] : '0),
            .dst_valid(arr_valid_a[i]), .dst(arr_a[i*DATA_W +: DATA_W])
        );
        skew_line #(.DEPTH(i), .W(DATA_W)) b_line (
            .clk(clk), .reset(reset), .flush(kill), .src_valid(fed),
            .src(fed ? b_rd_data[i*DATA_W +: DATA_W] : '0),
            .dst_valid(arr_valid_b[i]), .dst(arr_b[i*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq: random jobs through systolic_seq with operand buffers, a mac grid and a matmul scoreboard.
module tb_systolic_seq;
    localparam int N       = 4;
    localparam int DATA_W  = 8;
    localparam int KW      = 8;
    localparam int MAC_LAT = 2;
    localparam int D       = 1 + 2 * (N - 1) + MAC_LAT;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [KW-1:0]       k_len = '0;
    logic                busy, done, rd_en, acc_clear;
    logic [KW-1:0]       rd_addr;
    logic [N*DATA_W-1:0] a_rd_data = '0, b_rd_data = '0, arr_a, arr_b;
    logic [N-1:0]        arr_valid_a, arr_valid_b;
`ifdef SYSTOLIC_ABORT_EN
    logic abort = 1'b0;
    logic aborted;
`endif

    systolic_seq #(.N(N), .DATA_W(DATA_W), .KW(KW), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .arr_a(arr_a), .arr_valid_a(arr_valid_a), .arr_b(arr_b), .arr_valid_b(arr_valid_b),
        .acc_clear(acc_clear)
`ifdef SYSTOLIC_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // operand buffers: 1-cycle read latency, garbage when not read
    logic [DATA_W-1:0] amem [256][N];
    logic [DATA_W-1:0] bmem [256][N];
    always @(posedge clk)
        for (int i = 0; i < N; i++) begin
            a_rd_data[i*DATA_W +: DATA_W] <= rd_en ? amem[rd_addr][i] : DATA_W'($urandom);
            b_rd_data[i*DATA_W +: DATA_W] <= rd_en ? bmem[rd_addr][i] : DATA_W'($urandom);
        end

    // output-stationary mac grid: operand register, product register, accumulator
    logic [DATA_W-1:0] ga [N][N];
    logic [DATA_W-1:0] gb [N][N];
    logic              gva [N][N];
    logic              gvb [N][N];
    int                prod [N][N];
    int                acc [N][N];
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ga[i][j]   <= j == 0 ? arr_a[i*DATA_W +: DATA_W] : ga[i][j == 0 ? 0 : j-1];
                gva[i][j]  <= j == 0 ? arr_valid_a[i] : gva[i][j == 0 ? 0 : j-1];
                gb[i][j]   <= i == 0 ? arr_b[j*DATA_W +: DATA_W] : gb[i == 0 ? 0 : i-1][j];
                gvb[i][j]  <= i == 0 ? arr_valid_b[j] : gvb[i == 0 ? 0 : i-1][j];
                prod[i][j] <= (gva[i][j] && gvb[i][j]) ? int'(ga[i][j]) * int'(gb[i][j]) : 0;
                acc[i][j]  <= acc_clear ? 0 : acc[i][j] + prod[i][j];
            end

    // expectations keyed by cycle, plus a queue of pending jobs
    bit   exp_busy [int];
    bit   exp_clr [int];
    bit   exp_ab [int];
    int   exp_rd [int];
    int   flush_from = -1000;
    int   sb_cyc [$];
    logic [N*N*32-1:0] sb_c [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fill();
        for (int a = 0; a < 256; a++)
            for (int i = 0; i < N; i++) begin
                amem[a][i] = DATA_W'($urandom);
                bmem[a][i] = DATA_W'($urandom);
            end
    endtask

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // start a job in the current (idle) cycle; result is the plain matrix product
    task automatic issue(input int k, input bit hold, output int s, output int d);
        logic [N*N*32-1:0] c;
        int sum;
        s = cyc;
        k_len = KW'(k);
        start = 1'b1;
        d = s + 2 + k + (k != 0 ? D : 0);
        exp_clr[s+1] = 1'b1;
        for (int x = s + 1; x <= d; x++) exp_busy[x] = 1'b1;
        for (int a = 0; a < k; a++) exp_rd[s+2+a] = a;
        c = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                sum = 0;
                for (int a = 0; a < k; a++) sum += int'(amem[a][i]) * int'(bmem[a][j]);
                c[(i*N+j)*32 +: 32] = sum;
            end
        sb_cyc.push_back(d);
        sb_c.push_back(c);
        if (!hold) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    // the job in flight is killed: nothing from cycle 'from' on, and no done
    task automatic discard(input int from);
        for (int x = from; x < from + 400; x++) begin
            exp_busy.delete(x);
            exp_rd.delete(x);
            exp_clr.delete(x);
        end
        flush_from = from;
        void'(sb_cyc.pop_back());
        void'(sb_c.pop_back());
    endtask

    always @(negedge clk) begin : mon
        logic [N-1:0]        ev;
        logic [N*DATA_W-1:0] ea, eb;
        logic [N*N*32-1:0]   ec;
        int                  t, edc;
        chk("busy", busy, exp_busy.exists(cyc));
        chk("acc_clear", acc_clear, exp_clr.exists(cyc));
        if (exp_rd.exists(cyc)) chk("rd", {rd_en, rd_addr}, {1'b1, KW'(exp_rd[cyc])});
        else chk("rd_en", rd_en, 0);
        ea = '0;
        eb = '0;
        for (int i = 0; i < N; i++) begin
            t = cyc - 1 - i;
            ev[i] = exp_rd.exists(t) && !(t < flush_from && cyc >= flush_from);
            if (ev[i]) begin
                ea[i*DATA_W +: DATA_W] = amem[exp_rd[t]][i];
                eb[i*DATA_W +: DATA_W] = bmem[exp_rd[t]][i];
            end
        end
        chk("skew_a", {arr_valid_a, arr_a}, {ev, ea});
        chk("skew_b", {arr_valid_b, arr_b}, {ev, eb});
`ifdef SYSTOLIC_ABORT_EN
        chk("aborted", aborted, exp_ab.exists(cyc));
`endif
        if (done) begin
            edc = sb_cyc.size() != 0 ? sb_cyc.pop_front() : -1;
            ec = sb_c.size() != 0 ? sb_c.pop_front() : '0;
            chk("done_cycle", cyc, edc);
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    chk($sformatf("acc[%0d][%0d]", i, j), acc[i][j], ec[(i*N+j)*32 +: 32]);
        end
    end

    initial begin
        int s, d, s2, d2;
        fill();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step_to(4);

        issue(3, 1'b0, s, d);
        step_to(d + 1);

        for (int a = 0; a < 2; a++)
            for (int i = 0; i < N; i++) begin
                amem[a][i] = '0;
                bmem[a][i] = '0;
            end
        amem[0][0] = 1; amem[0][1] = 3; amem[1][0] = 2; amem[1][1] = 4;
        bmem[0][0] = 5; bmem[0][1] = 6; bmem[1][0] = 7; bmem[1][1] = 8;
        issue(2, 1'b0, s, d);
        step_to(d);
        chk("func_00", acc[0][0], 19);
        chk("func_01", acc[0][1], 22);
        chk("func_10", acc[1][0], 43);
        chk("func_11", acc[1][1], 50);
        step_to(d + 1);

        issue(0, 1'b0, s, d);
        step_to(d + 1);

        fill();
        issue(5, 1'b1, s, d);
        step_to(d);
        fill();
        step_to(d + 1);
        issue(3, 1'b0, s2, d2);
        step_to(d2 + 1);

        fill();
        issue(5, 1'b0, s, d);
        step_to(s + 4);
        #2;
        reset = 1'b1;
        discard(cyc);
        #1;
        chk("async_busy", busy, 0);
        chk("async_valid", {arr_valid_a, arr_valid_b, rd_en}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step_to(cyc + 12);
        fill();
        issue(4, 1'b0, s, d);
        step_to(d + 1);

`ifdef SYSTOLIC_ABORT_EN
        fill();
        issue(4, 1'b0, s, d);
        step_to(s + 8);
        abort = 1'b1;
        discard(cyc + 1);
        exp_ab[cyc+1] = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        step_to(cyc + 12);
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        step_to(cyc + 2);
`endif

        repeat (15) begin
            fill();
            issue($urandom_range(1, 12), 1'b0, s, d);
            step_to(d + 1 + $urandom_range(0, 2));
        end
        fill();
        issue(255, 1'b0, s, d);
        step_to(d + 1);

        step_to(cyc + 5);
        chk("pending_jobs", sb_cyc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_seq.md
Name: systolic_seq

Overview:
- Sequencer for an N x N output-stationary systolic grid of mac cells. It clears the accumulators, streams column k of A and row k of B from two operand buffers, and skews each lane so that lane i enters i cycles late.
- It waits out the array pipeline and then pulses done, when every acc_out holds the full dot product.
- Sits between the operand buffers and the mac grid, driving the grid's west (a) and north (b) edges.

Parameters:
- N, 4, array dimension (lanes per edge).
- DATA_W, 8, operand width, matching mac a_in/b_in.
- KW, 8, width of k_len and the read addresses; k_len ranges 0..2^KW-1.
- MAC_LAT, 2, cycles from an operand being registered in a mac to its product landing in acc_out.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- k_len  in  KW  inner dimension; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; results are stable.
- rd_en  out  1  read strobe to both operand buffers.
- rd_addr  out  KW  k index (A column k, B row k).
- a_rd_data  in  N*DATA_W  A column; 1-cycle read latency after rd_en.
- b_rd_data  in  N*DATA_W  B row; 1-cycle read latency.
- arr_a  out  N*DATA_W  skewed west-edge operands; lane i = bits [i*DATA_W +: DATA_W].
- arr_valid_a  out  N  per-lane valid_a.
- arr_b  out  N*DATA_W  skewed north-edge operands.
- arr_valid_b  out  N  per-lane valid_b.
- acc_clear  out  1  synchronous accumulator clear to all macs.
- abort  in  1  only present with SYSTOLIC_ABORT_EN.
- aborted  out  1  only present with SYSTOLIC_ABORT_EN.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; k counter and drain counter go to 0.
  - Outputs: busy=0, done=0, rd_en=0, rd_addr=0, acc_clear=0, aborted=0.
  - All skew registers clear: arr_valid_a=arr_valid_b=0, arr_a=arr_b=0.
  - Reset mid-job discards the job silently; no done pulse.
- IDLE:
  - start=1 latches k_len and moves to CLEAR.
  - start is ignored in every other state.
- CLEAR (1 cycle):
  - acc_clear=1.
  - Next state is FEED if k_len!=0; if k_len=0, next state is DONE, skipping FEED and DRAIN.
- FEED (exactly k_len cycles):
  - rd_en=1; rd_addr=k for k=0..k_len-1, incrementing each cycle.
  - After the k_len-1 read, moves to DRAIN.
- Lane timing:
  - Read data for a rd_en in cycle t is presented raw at cycle t+1.
  - Lane i of both edges, with valid=1, appears at cycle t+1+i; lane 0 has zero added delay.
  - Valid is the delayed rd_en; data on invalid cycles is don't-care but must be held at 0.
- DRAIN:
  - Lasts D = 1 + 2*(N-1) + MAC_LAT cycles; D=9 at the defaults.
  - The 1 covers read latency, 2*(N-1) covers skew plus hop propagation to mac[N-1][N-1], and MAC_LAT covers accumulation.
  - A down-counter loads D-1 on entry; the state exits to DONE when the counter reaches 0.
- DONE (1 cycle):
  - done=1, then IDLE.
  - start in the DONE cycle is ignored; start one cycle later is accepted.
- Width rules:
  - The k counter is KW bits and never wraps: k_len <= 2^KW-1, so the last address is k_len-1.
  - The drain counter is $clog2(D+1) bits.
- Invariants:
  - No rd_en outside FEED.
  - acc_clear is never high in the same cycle as any arr_valid.
  - busy=1 from CLEAR through DONE inclusive.

Optional Feature:
- Macro SYSTOLIC_ABORT_EN.
- Defined:
  - abort and aborted ports exist.
  - abort=1 in CLEAR, FEED or DRAIN moves to IDLE on the next edge.
  - On that edge all skew valids clear, rd_en drops, and aborted pulses for one cycle.
  - There is no done pulse; accumulator contents are undefined.
  - abort in IDLE or DONE is ignored; DONE completes normally.
- Undefined: the ports are absent, and behaviour is identical to the defined case with abort tied to 0.

Decomposition:
- Package systolic_pkg:
  - typedef enum state_t {IDLE, CLEAR, FEED, DRAIN, DONE}.
  - Default localparams DATA_W_DEF=8 and MAC_LAT_DEF=2.
  - Function drain_cycles(N, MAC_LAT) returning D.
- Sub-module skew_line #(DEPTH, W):
  - DEPTH-stage shift register of {valid, data}.
  - Async clear; DEPTH=0 is a pass-through.
  - Instantiated 2*N times via generate, lane i with DEPTH=i.

Test Plan:
- Nominal, N=4 and k_len=3, start at cycle 0:
  - CLEAR in cycle 1; rd_en in cycles 2..4 with addr 0,1,2.
  - Lane 3 valid in cycles 6..8; DRAIN in cycles 5..13; done in cycle 14; busy over 1..14.
- Functional check:
  - Bench mac grid with A=[[1,2],[3,4]] and B=[[5,6],[7,8]], padded in a 4x4 grid, k_len=2.
  - At done, acc[0][0]=19, acc[0][1]=22, acc[1][0]=43, acc[1][1]=50; other accumulators 0.
- k_len=0: start -> CLEAR then done next cycle; rd_en and all valids stay 0 throughout.
- Back-to-back:
  - start held high through job 1: no restart before IDLE; job 2 begins CLEAR the cycle after IDLE is entered.
  - Job 2 acc_clear wipes job 1 results.
- Reset mid-FEED (k_len=5, reset at addr 2):
  - All valids and busy drop asynchronously; no done.
  - A fresh start afterwards completes normally.
- SYSTOLIC_ABORT_EN:
  - abort in the third DRAIN cycle -> aborted pulses, state is IDLE next cycle, done never asserts.
  - abort in IDLE has no effect.
